// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA frame reader slice.
// Contents: default widths for pixel components, plane addresses and frame
// dimensions, plus the 2-bit reader FSM state encoding.
package cfa_pkg;

  localparam int PIXEL_W_DEF = 12;
  localparam int ADDR_W_DEF  = 17;
  localparam int DIM_W_DEF   = 11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/cfa_frame_reader_if.sv
// Pixel stream carrying one RGB pixel per valid/ready handshake, with
// start-of-frame, end-of-line and end-of-frame markers.
// Signals:
//   pixValid            producer has a pixel on the bus
//   pixReady            consumer accepts when pixValid && pixReady
//   pixRed/Green/Blue   colour components, PIXEL_W bits each
//   pixSof/Eol/Eof      frame position markers
// Modports: master = pixel producer (reader), slave = downstream consumer.
interface cfa_frame_reader_if
  import cfa_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF
);

  logic               pixValid;
  logic               pixReady;
  logic [PIXEL_W-1:0] pixRed;
  logic [PIXEL_W-1:0] pixGreen;
  logic [PIXEL_W-1:0] pixBlue;
  logic               pixSof;
  logic               pixEol;
  logic               pixEof;

  modport master (
    output pixValid, pixRed, pixGreen, pixBlue, pixSof, pixEol, pixEof,
    input  pixReady
  );

  modport slave (
    input  pixValid, pixRed, pixGreen, pixBlue, pixSof, pixEol, pixEof,
    output pixReady
  );

endinterface

// File: rtl/cfa_frame_reader_raster_counter.sv
// Raster-order row/column/linear-address counter.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               zero row, col and addr (frame start)
//   advance             step one pixel in raster order
//   row_max, col_max    frame dimensions (must be non-zero while advancing)
//   row, col, addr      current position; addr tracks row*col_max+col
//   last_col, last_pix  current position is the end of a row / of the frame
// The linear address is kept as its own incrementing register so no
// multiplier is needed.
module raster_counter
  import cfa_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [DIM_W-1:0]  row_max,
  input  logic [DIM_W-1:0]  col_max,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              last_pix
);

  assign last_col = (col == col_max - 1'b1);
  assign last_pix = last_col && (row == row_max - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + 1'b1;
      if (last_col) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfa_frame_reader.sv
// Reads the demosaiced red/green/blue plane memories in raster order and
// emits one RGB pixel per handshake on a valid/ready stream.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  one-cycle pulse, accepted only in IDLE
//   rowMax, colMax         frame size, latched on accepted start
//   redRead/greenRead/
//   blueRead               same-cycle plane data at readAddress
//   readAddress            registered linear plane address
//   busy                   accepted start .. done
//   done                   one-cycle pulse after the frame completes
//   pix                    pixel stream (master side)
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | loading pixels into the output register
// DRAIN  | last pixel loaded, waiting for it to be accepted
// DONE   | pulse done, drop busy, back to IDLE
module cfa_frame_reader
  import cfa_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DIM_W   = DIM_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   rowMax,
  input  logic [DIM_W-1:0]   colMax,
  input  logic [PIXEL_W-1:0] redRead,
  input  logic [PIXEL_W-1:0] greenRead,
  input  logic [PIXEL_W-1:0] blueRead,
  output logic [ADDR_W-1:0]  readAddress,
  output logic               busy,
  output logic               done,
  cfa_frame_reader_if.master pix
);

  state_t             state;
  logic [DIM_W-1:0]   row_max_q;
  logic [DIM_W-1:0]   col_max_q;
  logic [DIM_W-1:0]   row;
  logic [DIM_W-1:0]   col;
  logic               last_col;
  logic               last_pix;
  logic               load;
  logic               clear;
  logic               advance;

  // Output register may take a new pixel when empty or being drained.
  assign load    = !pix.pixValid || pix.pixReady;
  assign clear   = (state == S_IDLE) && start;
  // The address stays on the final pixel once it has been loaded.
  assign advance = (state == S_STREAM) && load && !last_pix;

  raster_counter #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .advance  (advance),
    .row_max  (row_max_q),
    .col_max  (col_max_q),
    .row      (row),
    .col      (col),
    .addr     (readAddress),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      row_max_q    <= '0;
      col_max_q    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pix.pixValid <= 1'b0;
      pix.pixRed   <= '0;
      pix.pixGreen <= '0;
      pix.pixBlue  <= '0;
      pix.pixSof   <= 1'b0;
      pix.pixEol   <= 1'b0;
      pix.pixEof   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            row_max_q <= rowMax;
            col_max_q <= colMax;
            busy      <= 1'b1;
            state     <= (rowMax == '0 || colMax == '0) ? S_DONE : S_STREAM;
          end
        end
        S_STREAM: begin
          if (load) begin
            pix.pixValid <= 1'b1;
            pix.pixRed   <= redRead;
            pix.pixGreen <= greenRead;
            pix.pixBlue  <= blueRead;
            pix.pixSof   <= (row == '0) && (col == '0);
            pix.pixEol   <= last_col;
            pix.pixEof   <= last_pix;
            if (last_pix) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pix.pixValid && pix.pixReady) begin
            pix.pixValid <= 1'b0;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
